// File: rtl/exp_adj_pkg.sv
// Shared definitions for the exponent-adjust pipeline: op encodings and default widths.
package exp_adj_pkg;

  localparam int unsigned EXP_W_SP = 8;
  localparam int unsigned EXP_W_DP = 11;

  typedef enum logic {
    OP_SUB = 1'b0,
    OP_ADD = 1'b1
  } exp_op_e;

endpackage

// File: rtl/exp_adj_core.sv
// Combinational W+1-bit exponent add/subtract with borrow/carry flags and zero detect.
// Saturation on overflow/underflow is enabled by defining EXP_ADJUST_SAT_EN; otherwise results wrap.
module exp_adj_core
  import exp_adj_pkg::*;
#(
  parameter int unsigned W  = EXP_W_SP,
  parameter int unsigned SW = 5
) (
  input  logic [W-1:0]  exp_a,
  input  logic [SW-1:0] adj_b,
  input  exp_op_e       op,
  output logic [W-1:0]  exp_y,
  output logic          uflow,
  output logic          oflow,
  output logic          zero
);

  logic [W:0] a_ext;
  logic [W:0] b_ext;
  logic [W:0] res;

  assign a_ext = {1'b0, exp_a};
  assign b_ext = {{(W + 1 - SW){1'b0}}, adj_b};

  always_comb begin
    res   = '0;
    uflow = 1'b0;
    oflow = 1'b0;
    exp_y = '0;
    unique case (op)
      OP_ADD: begin
        res   = a_ext + b_ext;
        oflow = res[W];
      end
      default: begin
        // Top bit of the extended difference is the borrow out.
        res   = a_ext - b_ext;
        uflow = res[W];
      end
    endcase
`ifdef EXP_ADJUST_SAT_EN
    if (uflow) begin
      exp_y = '0;
    end else if (oflow) begin
      exp_y = '1;
    end else begin
      exp_y = res[W-1:0];
    end
`else
    exp_y = res[W-1:0];
`endif
  end

  assign zero = (exp_y == '0);

endmodule

// File: rtl/exp_adjust_pipe.sv
// Two-stage valid/ready exponent-adjust pipeline: S1 registers operands, S2 registers result.
// Optional saturation of the result is selected with the EXP_ADJUST_SAT_EN macro.
module exp_adjust_pipe
  import exp_adj_pkg::*;
#(
  parameter int unsigned W  = EXP_W_SP,
  parameter int unsigned SW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  exp_a,
  input  logic [SW-1:0] adj_b,
  input  logic          op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  exp_y,
  output logic          uflow,
  output logic          oflow,
  output logic          zero
);

  logic          s1_valid_q;
  logic [W-1:0]  s1_a_q;
  logic [SW-1:0] s1_b_q;
  exp_op_e       s1_op_q;

  logic          s2_valid_q;
  logic [W-1:0]  y_q;
  logic          uflow_q;
  logic          oflow_q;
  logic          zero_q;

  logic          s2_adv;
  logic [W-1:0]  core_y;
  logic          core_uflow;
  logic          core_oflow;
  logic          core_zero;

  // S2 may load whenever it is empty or its beat is leaving; S1 drains under the same condition.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  exp_adj_core #(
    .W  (W),
    .SW (SW)
  ) u_core (
    .exp_a (s1_a_q),
    .adj_b (s1_b_q),
    .op    (s1_op_q),
    .exp_y (core_y),
    .uflow (core_uflow),
    .oflow (core_oflow),
    .zero  (core_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_SUB;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q  <= exp_a;
        s1_b_q  <= adj_b;
        s1_op_q <= exp_op_e'(op);
      end
    end
  end

  // Result registers only move on a real S1 beat, so a stalled or drained S2 keeps its data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      uflow_q    <= 1'b0;
      oflow_q    <= 1'b0;
      zero_q     <= 1'b1;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        y_q     <= core_y;
        uflow_q <= core_uflow;
        oflow_q <= core_oflow;
        zero_q  <= core_zero;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign exp_y     = y_q;
  assign uflow     = uflow_q;
  assign oflow     = oflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_exp_adjust_pipe.sv
// Self-checking bench for exp_adjust_pipe: scoreboard against an arithmetic model plus directed cases.
module tb_exp_adjust_pipe;
  import exp_adj_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, op;
  logic [7:0] exp_a, exp_y;
  logic [4:0] adj_b;
  logic       uflow, oflow, zero;

  logic        in_valid_d, in_ready_d, out_valid_d, out_ready_d, op_d;
  logic [10:0] exp_a_d, exp_y_d;
  logic [5:0]  adj_b_d;
  logic        uflow_d, oflow_d, zero_d;

  exp_adjust_pipe #(.W(EXP_W_SP), .SW(5)) u_dut_sp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .exp_a(exp_a),
    .adj_b(adj_b), .op(op), .out_valid(out_valid), .out_ready(out_ready), .exp_y(exp_y),
    .uflow(uflow), .oflow(oflow), .zero(zero)
  );

  exp_adjust_pipe #(.W(EXP_W_DP), .SW(6)) u_dut_dp (
    .clk(clk), .rst(rst), .in_valid(in_valid_d), .in_ready(in_ready_d), .exp_a(exp_a_d),
    .adj_b(adj_b_d), .op(op_d), .out_valid(out_valid_d), .out_ready(out_ready_d),
    .exp_y(exp_y_d), .uflow(uflow_d), .oflow(oflow_d), .zero(zero_d)
  );

  // Packed result: bit18 uflow, bit17 oflow, bit16 zero, bits15:0 exponent.
  logic [31:0] act8, act11;
  assign act8  = {13'b0, uflow, oflow, zero, 8'h00, exp_y};
  assign act11 = {13'b0, uflow_d, oflow_d, zero_d, 5'b0, exp_y_d};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] model(input int a, input int b, input bit opv, input int w);
    int r, maxv, y;
    bit u, o;
    maxv = (1 << w) - 1;
    r    = opv ? a + b : a - b;
    u    = !opv && (r < 0);
    o    = opv && (r > maxv);
`ifdef EXP_ADJUST_SAT_EN
    y = u ? 0 : (o ? maxv : r);
`else
    y = r & maxv;
`endif
    return {13'b0, u, o, (y == 0), y[15:0]};
  endfunction

  logic [31:0] exp_q[$];
  bit          hold_v = 1'b0;
  logic [31:0] hold_val;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      hold_v = 1'b0;
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_outputs", act8, 32'h0001_0000);
      check("rst_dp_out_valid", 32'(out_valid_d), 0);
    end else begin
      if (hold_v) begin
        check("stall_valid", 32'(out_valid), 1);
        check("stall_data", act8, hold_val);
      end
      hold_v   = out_valid && !out_ready;
      hold_val = act8;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_beat: got 0x%0h expected none", act8);
        end else begin
          check("result", act8, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(int'(exp_a), int'(adj_b), op, 8));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat into an empty pipe; out_valid must rise exactly two cycles after acceptance.
  task automatic single(input logic [7:0] a, input logic [4:0] b, input bit o,
                        input logic [31:0] expv, input string nm);
    exp_a = a; adj_b = b; op = o; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check({nm, "_in_ready"}, 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check({nm, "_lat1"}, 32'(out_valid), 0);
    tick();
    @(negedge clk);
    check({nm, "_lat2"}, 32'(out_valid), 1);
    check(nm, act8, expv);
    tick();
  endtask

  task automatic drain(input string nm);
    int n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      tick();
      n++;
    end
    check({nm, "_drain_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent;
    bit  saw_block, acc;
    rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; exp_a = '0; adj_b = '0; op = 1'b0;
    in_valid_d = 1'b0; out_ready_d = 1'b1; exp_a_d = '0; adj_b_d = '0; op_d = 1'b0;

    // Hand-computed values pin the model.
    check("pin_sub", model(8'h80, 3, 1'b0, 8), 32'h0000_007D);
    check("pin_dp", model(11'h3FF, 63, 1'b0, 11), 32'h0000_03C0);
`ifdef EXP_ADJUST_SAT_EN
    check("pin_uflow", model(8'h02, 5, 1'b0, 8), 32'h0005_0000);
    check("pin_oflow", model(8'hFE, 4, 1'b1, 8), 32'h0002_00FF);
`else
    check("pin_uflow", model(8'h02, 5, 1'b0, 8), 32'h0004_00FD);
    check("pin_oflow", model(8'hFE, 4, 1'b1, 8), 32'h0002_0002);
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    single(8'h80, 5'd3, 1'b0, 32'h0000_007D, "sub_basic");
`ifdef EXP_ADJUST_SAT_EN
    single(8'h02, 5'd5, 1'b0, 32'h0005_0000, "uflow");
    single(8'hFE, 5'd4, 1'b1, 32'h0002_00FF, "oflow");
`else
    single(8'h02, 5'd5, 1'b0, 32'h0004_00FD, "uflow");
    single(8'hFE, 5'd4, 1'b1, 32'h0002_0002, "oflow");
`endif
    single(8'h05, 5'd5, 1'b0, 32'h0001_0000, "exact_zero");
    single(8'hE0, 5'd31, 1'b1, 32'h0000_00FF, "add_max");

    // Double-precision instance.
    exp_a_d = 11'h3FF; adj_b_d = 6'd63; op_d = 1'b0; in_valid_d = 1'b1;
    @(negedge clk);
    check("dp_in_ready", 32'(in_ready_d), 1);
    tick();
    in_valid_d = 1'b0;
    @(negedge clk);
    check("dp_lat1", 32'(out_valid_d), 0);
    tick();
    @(negedge clk);
    check("dp_lat2", 32'(out_valid_d), 1);
    check("dp_result", act11, 32'h0000_03C0);
    check("dp_model", act11, model(11'h3FF, 63, 1'b0, 11));
    tick();

    // Eight back-to-back beats with the sink stalled in cycles 3..6.
    sent = 0;
    saw_block = 1'b0;
    for (int cyc = 0; cyc < 40 && sent < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = 1'b1;
      exp_a     = 8'(32'h20 + sent * 7);
      adj_b     = 5'(sent);
      op        = sent[0];
      @(negedge clk);
      if (!in_ready) saw_block = 1'b1;
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
    end
    check("burst_in_ready_low", 32'(saw_block), 1);
    check("burst_sent", sent, 8);
    drain("burst");

    // Random traffic with occasional boundary exponents.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      exp_a     = 8'($urandom);
      if ($urandom_range(0, 7) == 0) exp_a = 8'($urandom_range(0, 1) * 255);
      adj_b     = 5'($urandom);
      op        = 1'($urandom);
      tick();
    end
    drain("random");

    // Reset with two beats in flight: both must vanish.
    out_ready = 1'b0;
    in_valid  = 1'b1; exp_a = 8'h40; adj_b = 5'd1; op = 1'b0;
    tick();
    exp_a = 8'h41; adj_b = 5'd2;
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_async_out_valid", 32'(out_valid), 0);
    check("rst_async_in_ready", 32'(in_ready), 1);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    single(8'h33, 5'd3, 1'b1, 32'h0000_0036, "post_rst");
    repeat (5) tick();
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exp_adjust_pipe.md
EXP_ADJUST_PIPE -- requirements
Module: exp_adjust_pipe

Interface
REQ-001 SHALL have parameter W, default 8: exponent width (8 for single, 11 for double precision).
REQ-002 SHALL have parameter SW, default 5: adjust-amount width (SW <= W).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port exp_a  input  W  exponent operand.
REQ-008 SHALL have port adj_b  input  SW  unsigned adjust amount (normalisation shift).
REQ-009 SHALL have port op  input  1  0 = exp_a - adj_b, 1 = exp_a + adj_b.
REQ-010 SHALL have port out_valid  output  1  result beat present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port exp_y  output  W  adjusted exponent.
REQ-013 SHALL have port uflow  output  1  subtraction borrowed below zero.
REQ-014 SHALL have port oflow  output  1  addition carried past 2^W-1.
REQ-015 SHALL have port zero  output  1  exp_y equals 0.

Function
REQ-016 SHALL transfer an input beat when in_valid && in_ready, and an output beat when out_valid && out_ready.
REQ-017 SHALL use two register stages: S1 captures exp_a/adj_b/op; S2 holds exp_y and flags.
REQ-018 SHALL have latency 2 cycles from input acceptance to out_valid with no stall; throughput 1 beat/cycle.
REQ-019 SHALL advance S2 when S2 is empty or out_ready=1; S1 advances into S2 under the same condition.
REQ-020 SHALL drive in_ready = !S1.valid || S1 advancing, combinationally, with no dependency on in_valid.
REQ-021 SHALL hold exp_y and flags stable while out_valid=1 and out_ready=0.
REQ-022 SHALL compute in W+1 bits, with adj_b zero-extended: uflow = borrow (op=0), oflow = carry (op=1); the unused flag is 0.
REQ-023 SHALL give every accepted beat exactly one output beat, in order, with no loss or duplication under any in_valid/out_ready pattern.
REQ-024 SHALL compute zero on the final (post-saturation or wrapped) exp_y.
REQ-025 SHALL, when S1 is full and S2 is stalled, deassert in_ready and not overwrite S1.
REQ-026 SHALL, on simultaneous input acceptance and output drain with both stages full, shift and accept in the same cycle.

Reset
REQ-027 SHALL, while rst=0, clear S1/S2 valid bits and drive in_ready=1, out_valid=0, exp_y=0, uflow=0, oflow=0, zero=1.
REQ-028 SHALL discard in-flight beats when reset asserts mid-operation; the first beat accepted after reset deasserts appears after 2 cycles.

Configuration
REQ-029 SHALL, with macro EXP_ADJUST_SAT_EN defined, clamp exp_y to 0 on uflow and to 2^W-1 on oflow.
REQ-030 SHALL, without EXP_ADJUST_SAT_EN, wrap exp_y modulo 2^W; flags are raised identically in both builds.

Structure
REQ-031 SHALL take op encodings OP_SUB=0 and OP_ADD=1 and default widths EXP_W_SP=8 and EXP_W_DP=11 from shared package exp_adj_pkg.
REQ-032 SHALL place the combinational W+1-bit add/sub, flag and saturation logic in sub-module exp_adj_core, instantiated between S1 and S2.

Verification
REQ-033 SHALL cover: W=8, a=0x80, b=3, op=0, out_ready=1 -> exp_y=0x7D, flags 0, out_valid exactly 2 cycles after acceptance.
REQ-034 SHALL cover: a=0x02, b=5, op=0 -> uflow=1; exp_y=0x00 and zero=1 with SAT_EN; exp_y=0xFD and zero=0 without.
REQ-035 SHALL cover: a=0xFE, b=4, op=1 -> oflow=1; exp_y=0xFF with SAT_EN; exp_y=0x02 without.
REQ-036 SHALL cover: 8 back-to-back beats with out_ready held 0 for cycles 3-6 -> in_ready=0 once both stages are full, all 8 results in order, outputs stable during stall.
REQ-037 SHALL cover: rst pulsed low with 2 beats in flight -> out_valid=0 immediately, neither beat ever emitted, next beat emitted at latency 2.
REQ-038 SHALL cover: W=11, SW=6, a=0x3FF, b=63, op=0 -> exp_y=0x3C0, flags 0.
